// File: rtl/pipo_load_arbiter_if.sv
// Bus between the requesters and the shared holding-register arbiter.
interface pipo_load_arbiter_if #(
   parameter int NREQ  = 4,
   parameter int WIDTH = 3,
   parameter int IDW   = 2
);
   logic [NREQ-1:0]       req;
   logic [NREQ*WIDTH-1:0] din;
   logic [NREQ-1:0]       grant;
   logic [NREQ-1:0]       ack;
   logic [WIDTH-1:0]      q;
   logic                  busy;
   logic [IDW-1:0]        last_id;

   modport master (
      output req,
      output din,
      input  grant,
      input  ack,
      input  q,
      input  busy,
      input  last_id
   );

   modport slave (
      input  req,
      input  din,
      output grant,
      output ack,
      output q,
      output busy,
      output last_id
   );
endinterface

// File: rtl/pipo_load_arbiter.sv
// Round-robin arbiter that shares one parallel-in/parallel-out register
// among NREQ requesters, with a programmable idle gap after each ack.
module pipo_load_arbiter #(
   parameter int NREQ  = 4,
   parameter int WIDTH = 3,
   parameter int IDW   = 2,
   parameter int GAP   = 2
) (
   input logic                clk,
   input logic                rst,
   pipo_load_arbiter_if.slave bus
);

   typedef enum logic [1:0] {IDLE, LOAD, ACK} state_t;

   localparam logic [NREQ-1:0] ONE_HOT0 = {{(NREQ-1){1'b0}}, 1'b1};

   state_t           state;
   logic [IDW-1:0]   win;
   logic [IDW-1:0]   rr_ptr;
   logic [3:0]       gap_cnt;
   logic [IDW-1:0]   pick;
   logic             pick_valid;
   logic [IDW:0]     scan_sum;
   logic [IDW-1:0]   scan_idx;
   logic [WIDTH-1:0] din_arr [NREQ];

   // Split the flat data bus into one slice per requester.
   always_comb begin
      for (int i = 0; i < NREQ; i++) begin
         din_arr[i] = bus.din[i*WIDTH +: WIDTH];
      end
   end

   // Find the first requester at or above the rotation pointer, wrapping at NREQ.
   always_comb begin
      pick       = '0;
      pick_valid = 1'b0;
      scan_sum   = '0;
      scan_idx   = '0;
      for (int k = 0; k < NREQ; k++) begin
         scan_sum = {1'b0, rr_ptr} + (IDW+1)'(k);
         if (scan_sum >= (IDW+1)'(NREQ)) begin
            scan_sum = scan_sum - (IDW+1)'(NREQ);
         end
         scan_idx = scan_sum[IDW-1:0];
         if (!pick_valid && bus.req[scan_idx]) begin
            pick_valid = 1'b1;
            pick       = scan_idx;
         end
      end
   end

   // Sequencer: arbitrate in IDLE, load the register in LOAD, pulse ack in ACK.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= IDLE;
         win         <= '0;
         rr_ptr      <= '0;
         gap_cnt     <= '0;
         bus.grant   <= '0;
         bus.ack     <= '0;
         bus.q       <= '0;
         bus.last_id <= '0;
      end else begin
         case (state)
            IDLE: begin
               bus.ack <= '0;
               if (gap_cnt != 4'd0) begin
                  gap_cnt <= gap_cnt - 4'd1;
               end else if (pick_valid) begin
                  win       <= pick;
                  bus.grant <= ONE_HOT0 << pick;
                  state     <= LOAD;
               end
            end
            LOAD: begin
               bus.q       <= din_arr[win];
               bus.last_id <= win;
               bus.grant   <= '0;
               bus.ack     <= ONE_HOT0 << win;
               state       <= ACK;
            end
            ACK: begin
               bus.ack <= '0;
               rr_ptr  <= (win == IDW'(NREQ-1)) ? '0 : win + IDW'(1);
               gap_cnt <= 4'(GAP);
               state   <= IDLE;
            end
            default: begin
               state     <= IDLE;
               bus.grant <= '0;
               bus.ack   <= '0;
            end
         endcase
      end
   end

   assign bus.busy = (state != IDLE) || (gap_cnt != 4'd0);

endmodule

// File: tb/tb_pipo_load_arbiter.sv
// Directed testbench for the round-robin shared-register arbiter.
module tb_pipo_load_arbiter;

   logic clk;
   logic rst;
   int   pass_count;
   int   fail_count;
   int   total_count;

   pipo_load_arbiter_if #(.NREQ(4), .WIDTH(3), .IDW(2)) bus ();

   pipo_load_arbiter #(.NREQ(4), .WIDTH(3), .IDW(2), .GAP(2)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   // Free-running clock.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic applyStimulus(input logic [3:0] r, input logic [11:0] d);
      bus.req = r;
      bus.din = d;
   endtask

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      total_count++;
      assert (observed === expected) pass_count++;
      else begin
         fail_count++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
      end
   endtask

   task automatic doReset();
      rst = 1'b1;
      tick();
      rst = 1'b0;
   endtask

   // Linear sequence of directed steps.
   initial begin
      logic [11:0] data4;
      pass_count  = 0;
      fail_count  = 0;
      total_count = 0;
      rst = 1'b1;
      applyStimulus(4'b0000, 12'd0);
      tick();
      tick();
      checkOutput("rst_q", 32'(bus.q), 32'h0);
      checkOutput("rst_grant", 32'(bus.grant), 32'h0);
      checkOutput("rst_ack", 32'(bus.ack), 32'h0);
      checkOutput("rst_busy", 32'(bus.busy), 32'h0);
      checkOutput("rst_last_id", 32'(bus.last_id), 32'h0);
      rst = 1'b0;

      // Single requester 0 with data 101.
      applyStimulus(4'b0001, {9'd0, 3'b101});
      tick();
      checkOutput("single_grant", 32'(bus.grant), 32'h1);
      checkOutput("single_ack_early", 32'(bus.ack), 32'h0);
      checkOutput("single_busy_load", 32'(bus.busy), 32'h1);
      tick();
      checkOutput("single_q", 32'(bus.q), 32'h5);
      checkOutput("single_ack", 32'(bus.ack), 32'h1);
      checkOutput("single_last_id", 32'(bus.last_id), 32'h0);
      checkOutput("single_grant_off", 32'(bus.grant), 32'h0);
      applyStimulus(4'b0000, {9'd0, 3'b101});
      tick();
      checkOutput("gap_busy1", 32'(bus.busy), 32'h1);
      checkOutput("gap_ack_off", 32'(bus.ack), 32'h0);
      tick();
      checkOutput("gap_busy2", 32'(bus.busy), 32'h1);
      tick();
      checkOutput("gap_busy_done", 32'(bus.busy), 32'h0);

      // All four requesting continuously: order 0,1,2,3,0 with 5-cycle ack spacing.
      doReset();
      data4 = {3'b100, 3'b011, 3'b010, 3'b001};
      applyStimulus(4'b1111, data4);
      for (int n = 0; n < 5; n++) begin
         repeat ((n == 0) ? 1 : 4) tick();
         checkOutput("rr_grant", 32'(bus.grant), 32'(4'b0001 << (n % 4)));
         tick();
         checkOutput("rr_ack", 32'(bus.ack), 32'(4'b0001 << (n % 4)));
         checkOutput("rr_q", 32'(bus.q), 32'((n % 4) + 1));
         checkOutput("rr_last_id", 32'(bus.last_id), 32'(n % 4));
      end

      // Rotation skip: req=1010 from pointer 0 picks 1, then pointer 2 picks 3.
      doReset();
      applyStimulus(4'b1010, data4);
      tick();
      checkOutput("skip_grant1", 32'(bus.grant), 32'h2);
      tick();
      checkOutput("skip_ack1", 32'(bus.ack), 32'h2);
      checkOutput("skip_q1", 32'(bus.q), 32'h2);
      repeat (4) tick();
      checkOutput("skip_grant3", 32'(bus.grant), 32'h8);
      tick();
      checkOutput("skip_ack3", 32'(bus.ack), 32'h8);
      checkOutput("skip_q3", 32'(bus.q), 32'h4);
      checkOutput("skip_last_id3", 32'(bus.last_id), 32'h3);

      // Late request arriving while the gap counter is 1.
      applyStimulus(4'b0000, data4);
      tick();
      tick();
      checkOutput("late_busy_gap1", 32'(bus.busy), 32'h1);
      applyStimulus(4'b0100, data4);
      tick();
      checkOutput("late_no_grant", 32'(bus.grant), 32'h0);
      checkOutput("late_busy_off", 32'(bus.busy), 32'h0);
      tick();
      checkOutput("late_grant", 32'(bus.grant), 32'h4);
      tick();
      checkOutput("late_ack", 32'(bus.ack), 32'h4);
      checkOutput("late_q", 32'(bus.q), 32'h3);
      checkOutput("late_last_id", 32'(bus.last_id), 32'h2);

      // Dropping req during LOAD does not abort the load.
      data4 = {3'b100, 3'b011, 3'b010, 3'b110};
      applyStimulus(4'b0000, data4);
      repeat (3) tick();
      applyStimulus(4'b0001, data4);
      tick();
      checkOutput("drop_grant", 32'(bus.grant), 32'h1);
      applyStimulus(4'b0000, data4);
      tick();
      checkOutput("drop_ack", 32'(bus.ack), 32'h1);
      checkOutput("drop_q", 32'(bus.q), 32'h6);

      // Reset asserted during ACK clears everything immediately.
      repeat (3) tick();
      applyStimulus(4'b0010, data4);
      tick();
      checkOutput("mid_grant", 32'(bus.grant), 32'h2);
      tick();
      checkOutput("mid_ack", 32'(bus.ack), 32'h2);
      checkOutput("mid_q", 32'(bus.q), 32'h2);
      rst = 1'b1;
      #1;
      checkOutput("mid_rst_ack", 32'(bus.ack), 32'h0);
      checkOutput("mid_rst_grant", 32'(bus.grant), 32'h0);
      checkOutput("mid_rst_q", 32'(bus.q), 32'h0);
      checkOutput("mid_rst_busy", 32'(bus.busy), 32'h0);
      checkOutput("mid_rst_last_id", 32'(bus.last_id), 32'h0);
      applyStimulus(4'b0000, data4);
      tick();
      rst = 1'b0;
      tick();
      tick();
      checkOutput("post_rst_busy", 32'(bus.busy), 32'h0);
      checkOutput("post_rst_grant", 32'(bus.grant), 32'h0);
      checkOutput("post_rst_ack", 32'(bus.ack), 32'h0);

      $display("%0d/%0d checks passed", pass_count, total_count);
      $finish;
   end

endmodule
